alu_issue_queue: RTL and testbench

//  Upstream feeder and result collector for the 8-bit registered ALU stage.
//  - Accepts tagged operations over a valid/ready handshake and buffers them in a small FIFO.
//  - Issues one operation per clock to the ALU.
//  - Realigns the ALU result (1-cycle lag) and carry (2-cycle lag) into a single tagged result beat.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_issue_queue_if.sv | 55 +++++
 rtl/alu_op_fifo.sv | 78 +++++++
 rtl/alu_issue_queue.sv | 194 +++++++++++++++++++
 tb/tb_alu_issue_queue.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit registered ALU and the blocks around it.
//   ALU_W          datapath width of the ALU
//   ALU_RES_LAG    clocks from operand load to alu_out being valid
//   ALU_CARRY_LAG  clocks from operand load to alu_cout being valid
//   alu_op_e       ALU operation encodings
//   op_has_carry   1 for operations whose carry out is meaningful
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W         = 8;
    localparam int ALU_RES_LAG   = 1;
    localparam int ALU_CARRY_LAG = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_XOR = 2'd1,
        OP_DEC = 2'd2,
        OP_ILL = 2'd3
    } alu_op_e;

    function automatic logic op_has_carry(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_queue_if
// Bundles the three buses of the ALU issue queue.
//   Operation input : in_vld, in_rdy, in_a, in_b, in_op, in_cin, in_tag, flush
//   ALU side        : alu_a, alu_b, alu_op, alu_cin, alu_rst, alu_out, alu_cout
//   Result output   : res_vld, res_data, res_cout, res_tag, res_err
// Modports
//   slave  : the issue queue itself
//   master : the environment (operation source, ALU and result sink)
// ---------------------------------------------------------------------------
interface alu_issue_queue_if #(
    parameter int TAG_W = 4
);
    import alu_pkg::*;

    logic               in_vld;
    logic               in_rdy;
    logic [ALU_W-1:0]   in_a;
    logic [ALU_W-1:0]   in_b;
    logic [1:0]         in_op;
    logic               in_cin;
    logic [TAG_W-1:0]   in_tag;
    logic               flush;

    logic [ALU_W-1:0]   alu_a;
    logic [ALU_W-1:0]   alu_b;
    logic [1:0]         alu_op;
    logic               alu_cin;
    logic               alu_rst;
    logic [ALU_W-1:0]   alu_out;
    logic               alu_cout;

    logic               res_vld;
    logic [ALU_W-1:0]   res_data;
    logic               res_cout;
    logic [TAG_W-1:0]   res_tag;
    logic               res_err;

    modport slave (
        input  in_vld, in_a, in_b, in_op, in_cin, in_tag, flush,
        output in_rdy,
        output alu_a, alu_b, alu_op, alu_cin, alu_rst,
        input  alu_out, alu_cout,
        output res_vld, res_data, res_cout, res_tag, res_err
    );

    modport master (
        output in_vld, in_a, in_b, in_op, in_cin, in_tag, flush,
        input  in_rdy,
        input  alu_a, alu_b, alu_op, alu_cin, alu_rst,
        output alu_out, alu_cout,
        input  res_vld, res_data, res_cout, res_tag, res_err
    );

endinterface

// File: rtl/alu_op_fifo.sv
// ---------------------------------------------------------------------------
// alu_op_fifo
// Synchronous FIFO with occupancy count and no write-to-read bypass: an
// entry pushed on one edge is first visible on o_rdata after that edge.
// Parameters
//   DEPTH   number of entries, power of two, minimum 2
//   W       entry width
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous reset, active low
//   i_flush   synchronous clear; push and pop are ignored while high
//   i_push    write i_wdata (ignored when full unless popping too)
//   i_wdata   entry to write
//   i_pop     advance the read pointer (ignored when empty)
//   o_rdata   head entry
//   o_count   number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module alu_op_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // A push at full is only taken when the same edge frees a slot.
    assign w_do_pop  = i_pop  & ~i_flush & (r_count != '0);
    assign w_do_push = i_push & ~i_flush & ((r_count != CW'(DEPTH)) | w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
// Feeder and result collector for the 8-bit registered ALU. Tagged operations
// are buffered in a FIFO, issued one per clock to the ALU, and the ALU result
// (1-cycle lag) and carry (2-cycle lag) are realigned into one tagged result
// beat, three clocks after issue, in acceptance order.
// Parameters
//   DEPTH   FIFO entries, power of two, minimum 2
//   TAG_W   width of the caller-supplied tag (must match the interface)
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous reset, active low
//   bus       alu_issue_queue_if.slave: operation input handshake and flush,
//             registered ALU operand/control outputs, ALU result/carry
//             inputs, and the result strobe with data, carry, tag and error
// ---------------------------------------------------------------------------
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    alu_issue_queue_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 2 * ALU_W + 2 + 1 + TAG_W;

    logic [EW-1:0]    w_wdata;
    logic [EW-1:0]    w_rdata;
    logic [CW-1:0]    w_count;
    logic             w_rdy;
    logic             w_push;
    logic             w_pop;
    logic [ALU_W-1:0] w_head_a;
    logic [ALU_W-1:0] w_head_b;
    logic [1:0]       w_head_op;
    logic             w_head_cin;
    logic [TAG_W-1:0] w_head_tag;

    logic [ALU_W-1:0] r_alu_a;
    logic [ALU_W-1:0] r_alu_b;
    logic [1:0]       r_alu_op;
    logic             r_alu_cin;
    logic             r_alu_rst;

    logic             r_s0_v;
    logic [TAG_W-1:0] r_s0_tag;
    logic             r_s0_err;
    logic [1:0]       r_s0_op;
    logic             r_s1_v;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_err;
    logic [1:0]       r_s1_op;
    logic             r_s2_v;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_err;
    logic [1:0]       r_s2_op;
    logic [ALU_W-1:0] r_s2_data;

    logic             r_res_vld;
    logic [ALU_W-1:0] r_res_data;
    logic             r_res_cout;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_err;

    logic             w_s2_live;
    logic             w_s2_ok;

    // in_rdy is forced low while reset is held so nothing is offered a
    // handshake that the cleared FIFO would silently drop.
    assign w_rdy   = i_rst_n & (w_count < CW'(DEPTH)) & ~bus.flush;
    assign w_push  = bus.in_vld & w_rdy;
    assign w_pop   = (w_count != '0) & ~bus.flush;
    assign w_wdata = {bus.in_a, bus.in_b, bus.in_op, bus.in_cin, bus.in_tag};
    assign {w_head_a, w_head_b, w_head_op, w_head_cin, w_head_tag} = w_rdata;

    alu_op_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (bus.flush),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (w_count)
    );

    // Issue stage. Idle cycles and illegal ops both drive a harmless
    // XOR of zeros; an illegal op still occupies a slot so its error
    // result comes back in order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= OP_XOR;
            r_alu_cin <= 1'b0;
            r_alu_rst <= 1'b1;
            r_s0_v    <= 1'b0;
            r_s0_tag  <= '0;
            r_s0_err  <= 1'b0;
            r_s0_op   <= OP_XOR;
        end else begin
            r_alu_rst <= bus.flush;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= OP_XOR;
            r_alu_cin <= 1'b0;
            r_s0_v    <= 1'b0;
            r_s0_tag  <= '0;
            r_s0_err  <= 1'b0;
            r_s0_op   <= OP_XOR;
            if (w_pop) begin
                r_s0_v   <= 1'b1;
                r_s0_tag <= w_head_tag;
                r_s0_op  <= w_head_op;
                if (w_head_op == OP_ILL) begin
                    r_s0_err <= 1'b1;
                end else begin
                    r_alu_a   <= w_head_a;
                    r_alu_b   <= w_head_b;
                    r_alu_op  <= w_head_op;
                    r_alu_cin <= w_head_cin;
                end
            end
        end
    end

    // Alignment pipeline. S2 captures alu_out while it holds the result of
    // the op now entering S2; the carry arrives one clock later and is
    // sampled directly into the result register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_tag  <= '0;
            r_s1_err  <= 1'b0;
            r_s1_op   <= OP_XOR;
            r_s2_v    <= 1'b0;
            r_s2_tag  <= '0;
            r_s2_err  <= 1'b0;
            r_s2_op   <= OP_XOR;
            r_s2_data <= '0;
        end else begin
            r_s1_v    <= r_s0_v & ~bus.flush;
            r_s1_tag  <= r_s0_tag;
            r_s1_err  <= r_s0_err;
            r_s1_op   <= r_s0_op;
            r_s2_v    <= r_s1_v & ~bus.flush;
            r_s2_tag  <= r_s1_tag;
            r_s2_err  <= r_s1_err;
            r_s2_op   <= r_s1_op;
            r_s2_data <= bus.alu_out;
        end
    end

    // The S2 op is also dropped on a flush edge so a flushed op never
    // reaches res_vld.
    assign w_s2_live = r_s2_v & ~bus.flush;
    assign w_s2_ok   = w_s2_live & ~r_s2_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res_vld  <= 1'b0;
            r_res_data <= '0;
            r_res_cout <= 1'b0;
            r_res_tag  <= '0;
            r_res_err  <= 1'b0;
        end else begin
            r_res_vld  <= w_s2_live;
            r_res_data <= w_s2_ok ? r_s2_data : '0;
            r_res_cout <= w_s2_ok & op_has_carry(r_s2_op) & bus.alu_cout;
            r_res_tag  <= w_s2_live ? r_s2_tag : '0;
            r_res_err  <= w_s2_live & r_s2_err;
        end
    end

    assign bus.in_rdy   = w_rdy;
    assign bus.alu_a    = r_alu_a;
    assign bus.alu_b    = r_alu_b;
    assign bus.alu_op   = r_alu_op;
    assign bus.alu_cin  = r_alu_cin;
    assign bus.alu_rst  = r_alu_rst;
    assign bus.res_vld  = r_res_vld;
    assign bus.res_data = r_res_data;
    assign bus.res_cout = r_res_cout;
    assign bus.res_tag  = r_res_tag;
    assign bus.res_err  = r_res_err;

endmodule

// File: tb/tb_alu_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_queue
// Bench for alu_issue_queue together with a model of the registered ALU
// (result one clock after operand load, carry one clock after that).
// Directed operations are pushed with hand-computed expected results into a
// scoreboard queue; an independent monitor pops and compares every result
// beat, including its latency from acceptance.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int TAG_W   = 4;
    localparam int DEPTH   = 4;
    // Acceptance edge -> issue edge -> three alignment edges.
    localparam int LATENCY = 1 + ALU_RES_LAG + ALU_CARRY_LAG;

    typedef struct {
        logic [7:0]       data;
        logic             cout;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               accCycle;
    } exp_t;

    typedef struct {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [1:0]       op;
        logic             cin;
        logic [TAG_W-1:0] tag;
        logic [7:0]       expData;
        logic             expCout;
        logic             expErr;
    } vec_t;

    logic clk = 1'b0;
    logic rstN;
    int   cycle = 0;
    int   assertCount = 0;
    int   failCount = 0;
    exp_t sbQ[$];

    alu_issue_queue_if #(.TAG_W(TAG_W)) bus();

    alu_issue_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Registered ALU model driven by the DUT's alu_* outputs.
    logic [8:0] aluSum;
    logic [7:0] aluOutR;
    logic       aluC1;
    logic       aluCoutR;

    always_comb begin
        aluSum = '0;
        case (bus.alu_op)
            2'd0: aluSum = bus.alu_cin ? ({1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1)
                                       : ({1'b0, bus.alu_a} + {1'b0, bus.alu_b});
            2'd1: aluSum = {1'b0, bus.alu_a ^ bus.alu_b};
            2'd2: aluSum = {1'b0, bus.alu_a} - 9'd1;
            default: aluSum = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (bus.alu_rst) begin
            aluOutR  <= '0;
            aluC1    <= 1'b0;
            aluCoutR <= 1'b0;
        end else begin
            aluOutR  <= aluSum[7:0];
            aluC1    <= aluSum[8];
            aluCoutR <= aluC1;
        end
    end

    assign bus.alu_out  = aluOutR;
    assign bus.alu_cout = aluCoutR;

    function automatic vec_t mkVec(input logic [7:0] a, input logic [7:0] b,
                                   input logic [1:0] op, input logic cin,
                                   input logic [TAG_W-1:0] tag, input logic [7:0] d,
                                   input logic c, input logic e);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.cin = cin; v.tag = tag;
        v.expData = d; v.expCout = c; v.expErr = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    // Offers one op at a negedge, waits (bounded) for in_rdy, records the
    // expected result and returns just after the accepting edge.
    task automatic applyStimulus(input vec_t v, input logic expectRes, input logic checkRdy);
        exp_t e;
        int   waitCount;
        @(negedge clk);
        bus.in_vld = 1'b1;
        bus.in_a   = v.a;
        bus.in_b   = v.b;
        bus.in_op  = v.op;
        bus.in_cin = v.cin;
        bus.in_tag = v.tag;
        if (checkRdy) checkOutput("in_rdy_sustained", 32'(bus.in_rdy), 32'd1);
        waitCount = 0;
        while (bus.in_rdy !== 1'b1 && waitCount < 20) begin
            @(negedge clk);
            waitCount++;
        end
        if (bus.in_rdy !== 1'b1) begin
            checkOutput("in_rdy_timeout", 32'(bus.in_rdy), 32'd1);
            bus.in_vld = 1'b0;
            return;
        end
        if (expectRes) begin
            e.data     = v.expData;
            e.cout     = v.expCout;
            e.tag      = v.tag;
            e.err      = v.expErr;
            e.accCycle = cycle + 1;
            sbQ.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_vld = 1'b0;
        end
    endtask

    task automatic drain();
        int waitCount;
        waitCount = 0;
        while (sbQ.size() != 0 && waitCount < 50) begin
            @(negedge clk);
            bus.in_vld = 1'b0;
            waitCount++;
        end
        checkOutput("scoreboard_drain", 32'(sbQ.size()), 32'd0);
        idle(4);
    endtask

    // Result monitor: every res_vld beat must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rstN === 1'b1 && bus.res_vld === 1'b1) begin
                if (sbQ.size() == 0) begin
                    checkOutput("res_vld_unexpected", 32'(bus.res_vld), 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("res_data", 32'(bus.res_data), 32'(e.data));
                    checkOutput("res_cout", 32'(bus.res_cout), 32'(e.cout));
                    checkOutput("res_tag", 32'(bus.res_tag), 32'(e.tag));
                    checkOutput("res_err", 32'(bus.res_err), 32'(e.err));
                    checkOutput("res_latency", 32'(cycle - e.accCycle), 32'(LATENCY));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t t4[6];
        bus.in_vld = 1'b0;
        bus.in_a   = '0;
        bus.in_b   = '0;
        bus.in_op  = '0;
        bus.in_cin = 1'b0;
        bus.in_tag = '0;
        bus.flush  = 1'b0;
        rstN       = 1'b1;
        #1 rstN = 1'b0;
        #1;
        $display("[TB] reset values");
        checkOutput("rst_in_rdy", 32'(bus.in_rdy), 32'd0);
        checkOutput("rst_alu_rst", 32'(bus.alu_rst), 32'd1);
        checkOutput("rst_alu_op", 32'(bus.alu_op), 32'd1);
        checkOutput("rst_alu_a", 32'(bus.alu_a), 32'd0);
        checkOutput("rst_alu_b", 32'(bus.alu_b), 32'd0);
        checkOutput("rst_res_vld", 32'(bus.res_vld), 32'd0);
        checkOutput("rst_res_data", 32'(bus.res_data), 32'd0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("release_alu_rst_held", 32'(bus.alu_rst), 32'd1);
        @(negedge clk);
        checkOutput("release_alu_rst_fall", 32'(bus.alu_rst), 32'd0);
        checkOutput("release_in_rdy", 32'(bus.in_rdy), 32'd1);

        $display("[TB] single add");
        applyStimulus(mkVec(8'd100, 8'd27, 2'd0, 1'b0, 4'h1, 8'd127, 1'b0, 1'b0), 1'b1, 1'b0);
        drain();

        $display("[TB] back-to-back add and subtract");
        applyStimulus(mkVec(8'h80, 8'h80, 2'd0, 1'b0, 4'h2, 8'h00, 1'b1, 1'b0), 1'b1, 1'b0);
        applyStimulus(mkVec(8'd5, 8'd3, 2'd0, 1'b1, 4'h3, 8'h02, 1'b1, 1'b0), 1'b1, 1'b0);
        drain();

        $display("[TB] decrement and xor");
        applyStimulus(mkVec(8'h00, 8'h00, 2'd2, 1'b0, 4'h4, 8'hFF, 1'b1, 1'b0), 1'b1, 1'b0);
        applyStimulus(mkVec(8'hF0, 8'h0F, 2'd1, 1'b0, 4'h5, 8'hFF, 1'b0, 1'b0), 1'b1, 1'b0);
        drain();

        $display("[TB] sustained stream of six");
        t4[0] = mkVec(8'd10,  8'd20,  2'd0, 1'b0, 4'h0, 8'd30,  1'b0, 1'b0);
        t4[1] = mkVec(8'd200, 8'd100, 2'd0, 1'b0, 4'h1, 8'h2C,  1'b1, 1'b0);
        t4[2] = mkVec(8'hAA,  8'h55,  2'd1, 1'b0, 4'h2, 8'hFF,  1'b0, 1'b0);
        t4[3] = mkVec(8'd1,   8'd0,   2'd2, 1'b0, 4'h3, 8'h00,  1'b0, 1'b0);
        t4[4] = mkVec(8'd10,  8'd20,  2'd0, 1'b1, 4'h4, 8'hF6,  1'b0, 1'b0);
        t4[5] = mkVec(8'd20,  8'd10,  2'd0, 1'b1, 4'h5, 8'h0A,  1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(t4[i], 1'b1, 1'b1);
        end
        drain();

        $display("[TB] illegal op between legal ops");
        applyStimulus(mkVec(8'hFF, 8'h01, 2'd0, 1'b0, 4'h9, 8'h00, 1'b1, 1'b0), 1'b1, 1'b0);
        applyStimulus(mkVec(8'h12, 8'h34, 2'd3, 1'b1, 4'hA, 8'h00, 1'b0, 1'b1), 1'b1, 1'b0);
        applyStimulus(mkVec(8'h03, 8'h05, 2'd1, 1'b0, 4'hB, 8'h06, 1'b0, 1'b0), 1'b1, 1'b0);
        drain();

        $display("[TB] flush with ops queued and in flight");
        applyStimulus(mkVec(8'd1, 8'd1, 2'd0, 1'b0, 4'hC, 8'd2, 1'b0, 1'b0), 1'b1, 1'b0);
        applyStimulus(mkVec(8'd2, 8'd2, 2'd0, 1'b0, 4'h1, 8'd4, 1'b0, 1'b0), 1'b0, 1'b0);
        applyStimulus(mkVec(8'd3, 8'd3, 2'd0, 1'b0, 4'h2, 8'd6, 1'b0, 1'b0), 1'b0, 1'b0);
        applyStimulus(mkVec(8'd4, 8'd4, 2'd0, 1'b0, 4'h3, 8'd8, 1'b0, 1'b0), 1'b0, 1'b0);
        applyStimulus(mkVec(8'd5, 8'd5, 2'd0, 1'b0, 4'h4, 8'd10, 1'b0, 1'b0), 1'b0, 1'b0);
        @(negedge clk);
        bus.flush  = 1'b1;
        bus.in_vld = 1'b1;
        bus.in_a   = 8'h77;
        bus.in_tag = 4'hF;
        #1;
        checkOutput("flush_in_rdy", 32'(bus.in_rdy), 32'd0);
        @(negedge clk);
        checkOutput("flush_alu_rst_high", 32'(bus.alu_rst), 32'd1);
        bus.flush  = 1'b0;
        bus.in_vld = 1'b0;
        @(negedge clk);
        checkOutput("flush_alu_rst_low", 32'(bus.alu_rst), 32'd0);
        idle(8);
        checkOutput("flush_queue_empty", 32'(sbQ.size()), 32'd0);
        applyStimulus(mkVec(8'd7, 8'd8, 2'd0, 1'b0, 4'h6, 8'd15, 1'b0, 1'b0), 1'b1, 1'b0);
        drain();

        $display("[TB] async reset mid-stream");
        applyStimulus(mkVec(8'h55, 8'h11, 2'd0, 1'b0, 4'h7, 8'h66, 1'b0, 1'b0), 1'b0, 1'b0);
        applyStimulus(mkVec(8'h44, 8'h22, 2'd1, 1'b0, 4'h8, 8'h66, 1'b0, 1'b0), 1'b0, 1'b0);
        #2;
        rstN       = 1'b0;
        bus.in_vld = 1'b0;
        #1;
        checkOutput("midrst_alu_a", 32'(bus.alu_a), 32'd0);
        checkOutput("midrst_alu_op", 32'(bus.alu_op), 32'd1);
        checkOutput("midrst_alu_rst", 32'(bus.alu_rst), 32'd1);
        checkOutput("midrst_in_rdy", 32'(bus.in_rdy), 32'd0);
        checkOutput("midrst_res_vld", 32'(bus.res_vld), 32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        idle(6);
        applyStimulus(mkVec(8'd9, 8'd9, 2'd0, 1'b1, 4'hD, 8'h00, 1'b1, 1'b0), 1'b1, 1'b0);
        drain();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
